// File: rtl/tow_match_ctrl.sv
// Match controller for the tug-of-war playfield: key edge detection, point scoring, post-point freeze and restart, match end.
// Latency: a key press sampled at edge k gives its L/R pulse (and any score change) in cycle k+1.
// No backpressure: presses are ignored during HOLD/RESTART/DONE, and simultaneous L+R presses cancel each other.
//
// Ports:
//   Clock, Reset             - rising-edge clock, synchronous active-high reset
//   keyL, keyR               - pre-synchronized player key levels
//   leftEndOn, rightEndOn    - outermost field lights
//   L, R                     - one-cycle move pulses to the field
//   win1, win2               - one-cycle restart pulses after a left/right point
//   score1, score2           - per-player scores
//   busy, gameOver           - HOLD/RESTART indicator, match-finished indicator
//   champ1, champ2           - match winner, valid while gameOver
module tow_match_ctrl #(
   parameter int MATCH_POINTS = 7,
   parameter int SW           = 3,
   parameter int HOLD_CYCLES  = 4,
   parameter int HW           = 3
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          keyL,
   input  logic          keyR,
   input  logic          leftEndOn,
   input  logic          rightEndOn,
   output logic          L,
   output logic          R,
   output logic          win1,
   output logic          win2,
   output logic [SW-1:0] score1,
   output logic [SW-1:0] score2,
   output logic          busy,
   output logic          gameOver,
   output logic          champ1,
   output logic          champ2
);

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      HOLD    = 2'd1,
      RESTART = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [SW-1:0] MATCH_PTS = SW'(MATCH_POINTS);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   state_t          state, state_nxt;
   logic [SW-1:0]   score1_nxt, score2_nxt;
   logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
   logic [1:0]      last_pt, last_pt_nxt;
   logic            l_nxt, r_nxt;
   logic            keyL_q, keyR_q;
   logic            press_l, press_r;

   // Key history tracks the inputs in every state (and during Reset), so a
   // key held across reset release or across a freeze never counts as a press.
   assign press_l = keyL & ~keyL_q;
   assign press_r = keyR & ~keyR_q;

   always_ff @(posedge Clock) begin
      keyL_q <= keyL;
      keyR_q <= keyR;
      if (Reset) begin
         state    <= PLAY;
         score1   <= '0;
         score2   <= '0;
         hold_cnt <= '0;
         last_pt  <= 2'd0;
         L        <= 1'b0;
         R        <= 1'b0;
      end else begin
         state    <= state_nxt;
         score1   <= score1_nxt;
         score2   <= score2_nxt;
         hold_cnt <= hold_cnt_nxt;
         last_pt  <= last_pt_nxt;
         L        <= l_nxt;
         R        <= r_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      score1_nxt   = score1;
      score2_nxt   = score2;
      hold_cnt_nxt = hold_cnt;
      last_pt_nxt  = last_pt;
      l_nxt        = 1'b0;
      r_nxt        = 1'b0;

      unique case (state)
         PLAY: begin
            // Exactly one press is acted on; a tie cancels both.
            if (press_l && !press_r) begin
               l_nxt = 1'b1;
               if (leftEndOn) begin
                  score1_nxt   = score1 + SW'(1);
                  last_pt_nxt  = 2'd1;
                  hold_cnt_nxt = HOLD_LOAD;
                  state_nxt    = (score1_nxt == MATCH_PTS) ? DONE : HOLD;
               end
            end else if (press_r && !press_l) begin
               r_nxt = 1'b1;
               if (rightEndOn) begin
                  score2_nxt   = score2 + SW'(1);
                  last_pt_nxt  = 2'd2;
                  hold_cnt_nxt = HOLD_LOAD;
                  state_nxt    = (score2_nxt == MATCH_PTS) ? DONE : HOLD;
               end
            end
         end
         HOLD: begin
            // Counter runs HOLD_CYCLES-1 down to 0, one state cycle per count.
            if (hold_cnt == '0) begin
               state_nxt = RESTART;
            end else begin
               hold_cnt_nxt = hold_cnt - HW'(1);
            end
         end
         RESTART: begin
            state_nxt = PLAY;
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = PLAY;
         end
      endcase
   end

   // Moore decodes of state.
   assign busy     = (state == HOLD) || (state == RESTART);
   assign win1     = (state == RESTART) && (last_pt == 2'd1);
   assign win2     = (state == RESTART) && (last_pt != 2'd1);
   assign gameOver = (state == DONE);
   assign champ1   = (state == DONE) && (last_pt == 2'd1);
   assign champ2   = (state == DONE) && (last_pt == 2'd2);

endmodule

// File: tb/tb_tow_match_ctrl.sv
module tb_tow_match_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       keyL, keyR, leftEndOn, rightEndOn;
   logic       L, R, win1, win2, busy, gameOver, champ1, champ2;
   logic [2:0] score1, score2;

   int checks   = 0;
   int failures = 0;

   tow_match_ctrl #(
      .MATCH_POINTS(7), .SW(3), .HOLD_CYCLES(4), .HW(3)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .keyL(keyL), .keyR(keyR),
      .leftEndOn(leftEndOn), .rightEndOn(rightEndOn),
      .L(L), .R(R), .win1(win1), .win2(win2),
      .score1(score1), .score2(score2),
      .busy(busy), .gameOver(gameOver),
      .champ1(champ1), .champ2(champ2)
   );

   always #5 Clock = ~Clock;

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full point cycle: press edge with end light lit, then 5 cycles (4 HOLD + 1 RESTART).
   task automatic left_point();
      keyL = 1'b0; leftEndOn = 1'b1;
      tick();
      keyL = 1'b1;
      tick();
      keyL = 1'b0; leftEndOn = 1'b0;
      repeat (5) tick();
   endtask

   task automatic right_point();
      keyR = 1'b0; rightEndOn = 1'b1;
      tick();
      keyR = 1'b1;
      tick();
      keyR = 1'b0; rightEndOn = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      Reset = 1'b1; keyL = 1'b1; keyR = 1'b0; leftEndOn = 1'b0; rightEndOn = 1'b0;
      #1;

      // 1: key held through reset release produces no press
      tick(); tick();
      Reset = 1'b0;
      check("rst_score1", score1, 0);
      check("rst_score2", score2, 0);
      check("rst_busy", busy, 0);
      check("rst_gameOver", gameOver, 0);
      check("rst_win1", win1, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("held_key_L", L, 0);
      end
      check("held_key_score1", score1, 0);

      // 2: single L pulse, no repeat while held
      keyL = 1'b0;
      tick();
      keyL = 1'b1;
      tick();
      check("press_L_pulse", L, 1);
      check("press_L_noR", R, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("press_L_held", L, 0);
      end
      check("press_L_score1", score1, 0);

      // 3: simultaneous presses cancel; then a lone R press
      keyL = 1'b0; keyR = 1'b0;
      tick();
      keyL = 1'b1; keyR = 1'b1;
      tick();
      check("tie_L", L, 0);
      check("tie_R", R, 0);
      tick();
      check("tie_L_next", L, 0);
      check("tie_R_next", R, 0);
      keyR = 1'b0;
      tick();
      keyR = 1'b1;
      tick();
      check("lone_R_pulse", R, 1);
      check("lone_R_noL", L, 0);
      tick();
      check("lone_R_once", R, 0);
      keyL = 1'b0; keyR = 1'b0;
      tick();

      // 4: scoring press with freeze and restart pulse
      left_point();
      left_point();
      check("pre_score1", score1, 2);
      check("pre_busy", busy, 0);
      leftEndOn = 1'b1;
      tick();
      keyL = 1'b1;
      tick();                                  // cycle k+1
      check("pt_L", L, 1);
      check("pt_busy_k1", busy, 1);
      check("pt_score1", score1, 3);
      check("pt_win1_k1", win1, 0);
      keyL = 1'b0; leftEndOn = 1'b0; keyR = 1'b1;
      tick();                                  // k+2
      check("hold_R_k2", R, 0);
      check("hold_L_k2", L, 0);
      check("pt_busy_k2", busy, 1);
      keyR = 1'b0;
      tick();                                  // k+3
      check("pt_busy_k3", busy, 1);
      check("pt_win1_k3", win1, 0);
      keyR = 1'b1;
      tick();                                  // k+4
      check("hold_R_k4", R, 0);
      check("pt_busy_k4", busy, 1);
      check("pt_win1_k4", win1, 0);
      keyR = 1'b0;
      tick();                                  // k+5
      check("pt_busy_k5", busy, 1);
      check("pt_win1_k5", win1, 1);
      check("pt_win2_k5", win2, 0);
      tick();                                  // k+6
      check("pt_busy_k6", busy, 0);
      check("pt_win1_k6", win1, 0);
      check("pt_R_k6", R, 0);
      tick();
      check("pt_R_k7", R, 0);
      check("pt_score2_unchanged", score2, 0);

      // 5: match point for the right player
      for (int i = 0; i < 6; i++) right_point();
      check("pre_score2", score2, 6);
      check("pre_score1_kept", score1, 3);
      rightEndOn = 1'b1;
      tick();
      keyR = 1'b1;
      tick();
      check("mp_R", R, 1);
      check("mp_score2", score2, 7);
      check("mp_gameOver", gameOver, 1);
      check("mp_champ2", champ2, 1);
      check("mp_champ1", champ1, 0);
      check("mp_busy", busy, 0);
      rightEndOn = 1'b0; leftEndOn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         keyL = i[0]; keyR = ~i[0];
         tick();
         check("done_L", L, 0);
         check("done_R", R, 0);
         check("done_win2", win2, 0);
         check("done_win1", win1, 0);
         check("done_gameOver", gameOver, 1);
      end
      check("done_score1", score1, 3);
      check("done_score2", score2, 7);

      // 6: reset in the 2nd HOLD cycle cancels the pending restart
      keyL = 1'b0; keyR = 1'b0; leftEndOn = 1'b0; Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("rst2_gameOver", gameOver, 0);
      check("rst2_score2", score2, 0);
      leftEndOn = 1'b1;
      tick();
      keyL = 1'b1;
      tick();                                  // HOLD cycle 1
      check("r6_busy_h1", busy, 1);
      check("r6_score1_h1", score1, 1);
      keyL = 1'b0; leftEndOn = 1'b0;
      tick();                                  // HOLD cycle 2
      check("r6_busy_h2", busy, 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("r6_busy_after", busy, 0);
      check("r6_score1_after", score1, 0);
      check("r6_score2_after", score2, 0);
      check("r6_win1_after", win1, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("r6_win1", win1, 0);
         check("r6_win2", win2, 0);
         check("r6_busy", busy, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tow_match_ctrl.md
Name: tow_match_ctrl

Overview:
- Match controller for the tug-of-war playfield.
- Turns raw player key levels into single-cycle L/R move pulses and cancels simultaneous presses.
- Detects end-of-field wins from the outermost light states and keeps per-player scores.
- After each point, holds the field frozen, then issues the one-cycle win1/win2 restart pulse that relights the center light; declares a match winner at MATCH_POINTS.

Parameters:
- MATCH_POINTS, 7: points needed to win the match; 1 <= MATCH_POINTS <= 2^SW-1.
- SW, 3: score counter width.
- HOLD_CYCLES, 4: freeze length after a point, in cycles; must be >= 1.
- HW, 3: hold counter width; must satisfy HOLD_CYCLES <= 2^HW-1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- keyL  in  1  left player key level, pre-synchronized, active-high.
- keyR  in  1  right player key level, pre-synchronized, active-high.
- leftEndOn  in  1  leftmost field light is lit.
- rightEndOn  in  1  rightmost field light is lit.
- L  out  1  one-cycle left move pulse to the field.
- R  out  1  one-cycle right move pulse to the field.
- win1  out  1  one-cycle restart pulse after a left-player point.
- win2  out  1  one-cycle restart pulse after a right-player point.
- score1  out  SW  left player score.
- score2  out  SW  right player score.
- busy  out  1  high in HOLD and RESTART.
- gameOver  out  1  high in DONE.
- champ1  out  1  left player won the match (valid when gameOver).
- champ2  out  1  right player won the match (valid when gameOver).

Behaviour:
- Reset (synchronous, active-high; clock Clock):
  - state=PLAY; score1=score2=0; L=R=0; holdCnt=0; lastPt=0.
  - win1=win2=busy=gameOver=champ1=champ2=0.
  - keyL_q<=keyL and keyR_q<=keyR during Reset, so a key held through reset release produces no press.
- Edge detection: pressL = keyL & ~keyL_q; pressR = keyR & ~keyR_q. keyL_q and keyR_q update every cycle in every state, so a key held through HOLD yields no press on return to PLAY.
- All outputs are registered or Moore decodes of state. Latency from the press-sampling edge to L/R: 1 cycle.
- PLAY:
  - pressL & pressR in the same cycle: both ignored; no pulse, no score change.
  - pressL only: L=1 for one cycle. If leftEndOn was also high at that edge, score1+1, lastPt=1, go to HOLD (or DONE if the new score1==MATCH_POINTS).
  - pressR only: symmetric, using R, rightEndOn, score2, lastPt=2.
  - A winning press still emits its L/R pulse.
- HOLD:
  - holdCnt loaded to HOLD_CYCLES-1 on entry; decrements each cycle; at 0, go to RESTART.
  - Lasts exactly HOLD_CYCLES cycles. L=R=0; presses ignored.
- RESTART: exactly 1 cycle. win1=1 if lastPt==1, else win2=1. Then go to PLAY.
- DONE: terminal until Reset. gameOver=1; champ1/champ2 per the final point; L=R=win1=win2=0; scores frozen.
- Scores never exceed MATCH_POINTS; no wrap.
- Reset asserted in any state (including mid-HOLD or during RESTART) returns to PLAY with scores cleared and no pending win pulse.
- busy = (state==HOLD) | (state==RESTART).

Test Plan:
1. Reset with keyL held high, release Reset, keep keyL high for 5 cycles -> L never pulses; score1=0.
2. keyL rises at edge k with leftEndOn=0 -> L=1 in cycle k+1 only; holding keyL for 10 cycles gives no further L.
3. keyL and keyR rise at the same edge -> L=R=0, scores unchanged; keyR released, then keyR rises alone -> single R pulse.
4. keyL rises with leftEndOn=1, score1=2, HOLD_CYCLES=4 -> L and busy high in cycle k+1; score1=3; busy high for cycles k+1..k+5; win1=1 in cycle k+5 only; PLAY at k+6; keyR pulses during HOLD are ignored.
5. score2=6, keyR rises with rightEndOn=1 -> score2=7, gameOver=1, champ2=1, no win2; later keys give no L/R until Reset.
6. Reset asserted in the 2nd HOLD cycle -> next cycle state=PLAY, scores 0, busy=0, and no win1/win2 ever appears.
